// File: rtl/fcp_sink_adapter.sv
// fcp_sink_adapter
//   Receive end of the packed FCP AXI-Stream link. Each beat is decoded into
//   its FCP fields and checked. Good beats go into a small FIFO. Malformed
//   beats are consumed and counted but never stored. The FIFO head is shown
//   as registered discrete fields with a valid/ready handshake.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   s_axis_fcp_tdata    packed beat: FCCL[31:0] QLEN[63:32] FCCR[95:64]
//                       VC[96 +: QUEUE_INDEX_WIDTH], zero padding above VC
//   s_axis_fcp_tvalid   beat valid
//   s_axis_fcp_tready   registered "FIFO not full"; 0 while in reset
//   fcp_valid           head entry valid (FIFO not empty)
//   fcp_ready           consumer ready; pop on fcp_valid & fcp_ready
//   fcp_vc/fccl/qlen/fccr  head entry fields, 0 when the FIFO is empty
//   fifo_level          current occupancy
//   stat_rx_count       good beats accepted (saturating)
//   stat_drop_count     malformed beats accepted (saturating)
module fcp_sink_adapter #(
    parameter int QUEUE_INDEX_WIDTH = 15,
    parameter int STAT_WIDTH        = 32,
    parameter int AXIS_WIDTH        = 512,
    parameter int FIFO_DEPTH        = 4,
    parameter int NUM_VC            = 32768,
    parameter int CNT_WIDTH         = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [AXIS_WIDTH-1:0]           s_axis_fcp_tdata,
    input  logic                            s_axis_fcp_tvalid,
    output logic                            s_axis_fcp_tready,
    output logic                            fcp_valid,
    input  logic                            fcp_ready,
    output logic [QUEUE_INDEX_WIDTH-1:0]    fcp_vc,
    output logic [STAT_WIDTH-1:0]           fcp_fccl,
    output logic [STAT_WIDTH-1:0]           fcp_qlen,
    output logic [STAT_WIDTH-1:0]           fcp_fccr,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [CNT_WIDTH-1:0]            stat_rx_count,
    output logic [CNT_WIDTH-1:0]            stat_drop_count
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int PAD_LSB = 96 + QUEUE_INDEX_WIDTH;

    localparam logic [LVL_W-1:0]             DEPTH_L  = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0]             ONE_L    = LVL_W'(1);
    localparam logic [QUEUE_INDEX_WIDTH:0]   NUM_VC_L = (QUEUE_INDEX_WIDTH+1)'(NUM_VC);

    // Parameter legality, rejected at elaboration.
    if (AXIS_WIDTH < PAD_LSB) begin : g_bad_axis
        $fatal(1, "AXIS_WIDTH must be at least 96+QUEUE_INDEX_WIDTH");
    end
    if (STAT_WIDTH != 32) begin : g_bad_stat
        $fatal(1, "STAT_WIDTH must be 32");
    end
    if (NUM_VC < 1 || NUM_VC > (1 << QUEUE_INDEX_WIDTH)) begin : g_bad_vc
        $fatal(1, "NUM_VC must be in 1..2^QUEUE_INDEX_WIDTH");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "FIFO_DEPTH must be a power of two, 2 or more");
    end

    typedef struct packed {
        logic [QUEUE_INDEX_WIDTH-1:0] vc;
        logic [STAT_WIDTH-1:0]        fccl;
        logic [STAT_WIDTH-1:0]        qlen;
        logic [STAT_WIDTH-1:0]        fccr;
    } entry_t;

    entry_t              beat;
    entry_t              head_q, head_next;
    entry_t              mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr, rd_ptr_inc;
    logic [LVL_W-1:0]    level, level_next;
    logic                tready_q;
    logic                pad_err, vc_err, malformed;
    logic                accept, push, drop, pop;

    // Beat decode.
    assign beat.fccl = s_axis_fcp_tdata[31:0];
    assign beat.qlen = s_axis_fcp_tdata[63:32];
    assign beat.fccr = s_axis_fcp_tdata[95:64];
    assign beat.vc   = s_axis_fcp_tdata[96 +: QUEUE_INDEX_WIDTH];

    if (AXIS_WIDTH > PAD_LSB) begin : g_pad
        assign pad_err = |s_axis_fcp_tdata[AXIS_WIDTH-1:PAD_LSB];
    end else begin : g_no_pad
        assign pad_err = 1'b0;
    end

    assign vc_err    = {1'b0, beat.vc} >= NUM_VC_L;
    assign malformed = pad_err | vc_err;

    // Malformed beats are still handshaken so the link never stalls on them.
    assign accept = s_axis_fcp_tvalid & tready_q;
    assign push   = accept & ~malformed;
    assign drop   = accept & malformed;
    assign pop    = fcp_valid & fcp_ready;

    assign rd_ptr_inc = rd_ptr + PTR_W'(1);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        level_next = level;
        unique case ({push, pop})
            2'b10:   level_next = level + ONE_L;
            2'b01:   level_next = level - ONE_L;
            default: level_next = level;
        endcase
    end

    // Next head register: reload on pop, or when a push lands in an empty FIFO.
    // With more than one entry the next head is the slot after rd_ptr, which
    // can never be the slot being written this cycle.
    always_comb begin
        head_next = head_q;
        if (pop) begin
            if (level == ONE_L) begin
                head_next = push ? beat : '0;
            end else begin
                head_next = mem[rd_ptr_inc];
            end
        end else if (push && level == '0) begin
            head_next = beat;
        end
    end

    // NOTE: the storage array has no reset; emptiness is carried by level and the pointers, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= beat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            level           <= '0;
            head_q          <= '0;
            tready_q        <= 1'b0;
            stat_rx_count   <= '0;
            stat_drop_count <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr_inc;
            level    <= level_next;
            head_q   <= head_next;
            // Registered from the next level: a pop while full reopens tready
            // only on the following cycle (no push-through).
            tready_q <= (level_next < DEPTH_L);
            if (push && stat_rx_count != '1)   stat_rx_count   <= stat_rx_count + CNT_WIDTH'(1);
            if (drop && stat_drop_count != '1) stat_drop_count <= stat_drop_count + CNT_WIDTH'(1);
        end
    end

    assign s_axis_fcp_tready = tready_q;
    assign fcp_valid         = (level != '0);
    assign fifo_level        = level;
    assign fcp_vc            = head_q.vc;
    assign fcp_fccl          = head_q.fccl;
    assign fcp_qlen          = head_q.qlen;
    assign fcp_fccr          = head_q.fccr;

endmodule

// File: tb/tb_fcp_sink_adapter.sv
// tb_fcp_sink_adapter
//   Self-checking bench for fcp_sink_adapter (NUM_VC=16, CNT_WIDTH=4).
//   A transaction-level model (a queue of FCP entries plus saturating
//   counters) predicts every output each cycle.
module tb_fcp_sink_adapter;

    localparam int QW    = 15;
    localparam int AW    = 512;
    localparam int DEPTH = 4;
    localparam int NVC   = 16;
    localparam int CW    = 4;
    localparam int MAXC  = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [AW-1:0]     s_axis_fcp_tdata;
    logic              s_axis_fcp_tvalid;
    logic              s_axis_fcp_tready;
    logic              fcp_valid;
    logic              fcp_ready;
    logic [QW-1:0]     fcp_vc;
    logic [31:0]       fcp_fccl, fcp_qlen, fcp_fccr;
    logic [2:0]        fifo_level;
    logic [CW-1:0]     stat_rx_count, stat_drop_count;

    fcp_sink_adapter #(
        .QUEUE_INDEX_WIDTH(QW), .STAT_WIDTH(32), .AXIS_WIDTH(AW),
        .FIFO_DEPTH(DEPTH), .NUM_VC(NVC), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_fcp_tdata(s_axis_fcp_tdata), .s_axis_fcp_tvalid(s_axis_fcp_tvalid),
        .s_axis_fcp_tready(s_axis_fcp_tready),
        .fcp_valid(fcp_valid), .fcp_ready(fcp_ready),
        .fcp_vc(fcp_vc), .fcp_fccl(fcp_fccl), .fcp_qlen(fcp_qlen), .fcp_fccr(fcp_fccr),
        .fifo_level(fifo_level),
        .stat_rx_count(stat_rx_count), .stat_drop_count(stat_drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [QW-1:0] vc;
        logic [31:0]   fccl, qlen, fccr;
    } ent_t;

    ent_t q[$];
    int   m_rx, m_drop;
    logic m_tready;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        ent_t e;
        e = '{vc: '0, fccl: '0, qlen: '0, fccr: '0};
        if (q.size() != 0) e = q[0];
        check("tready",  64'(s_axis_fcp_tready), 64'(m_tready));
        check("valid",   64'(fcp_valid), 64'(q.size() != 0));
        check("vc",      64'(fcp_vc), 64'(e.vc));
        check("fccl",    64'(fcp_fccl), 64'(e.fccl));
        check("qlen",    64'(fcp_qlen), 64'(e.qlen));
        check("fccr",    64'(fcp_fccr), 64'(e.fccr));
        check("level",   64'(fifo_level), 64'(q.size()));
        check("rx_cnt",  64'(stat_rx_count), 64'(m_rx));
        check("drop_cnt",64'(stat_drop_count), 64'(m_drop));
    endtask

    function automatic logic [AW-1:0] make_beat(input logic [QW-1:0] vc, input logic [31:0] fccl,
                                                  input logic [31:0] qlen, input logic [31:0] fccr,
                                                  input int pad_bit);
        logic [AW-1:0] t;
        t = '0;
        t[31:0]  = fccl;
        t[63:32] = qlen;
        t[95:64] = fccr;
        t[110:96] = vc;
        if (pad_bit >= 0) t[pad_bit] = 1'b1;
        return t;
    endfunction

    function automatic logic [AW-1:0] rand_beat(input logic bad);
        logic [QW-1:0] vc;
        int pad;
        pad = -1;
        vc  = QW'($urandom_range(0, NVC - 1));
        if (bad) begin
            if ($urandom_range(0, 1) == 0) vc = QW'($urandom_range(NVC, 32767));
            else pad = $urandom_range(111, AW - 1);
        end
        return make_beat(vc, $urandom, $urandom, $urandom, pad);
    endfunction

    // One clock cycle: drive at the falling edge, check, then advance the model
    // across the rising edge.
    task automatic cycle(input logic tv, input logic [AW-1:0] td, input logic rdy);
        logic acc, pop, good;
        ent_t e;
        s_axis_fcp_tvalid = tv;
        s_axis_fcp_tdata  = td;
        fcp_ready         = rdy;
        #1;
        compare_all();
        acc  = tv && m_tready;
        pop  = (q.size() != 0) && rdy;
        good = (td[AW-1:111] == '0) && (int'(td[110:96]) < NVC);
        @(posedge clk);
        if (pop) q.delete(0);
        if (acc && good) begin
            e.vc = td[110:96]; e.fccl = td[31:0]; e.qlen = td[63:32]; e.fccr = td[95:64];
            q.push_back(e);
            if (m_rx < MAXC) m_rx++;
        end
        if (acc && !good && m_drop < MAXC) m_drop++;
        m_tready = (q.size() < DEPTH);
        @(negedge clk);
    endtask

    // Assert reset mid-cycle, check the immediate effect, release at a falling
    // edge and check tready only rises on the first rising edge after release.
    task automatic apply_reset();
        #2 rst_n = 1'b0;
        q.delete();
        m_rx = 0; m_drop = 0; m_tready = 1'b0;
        #1 compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        s_axis_fcp_tvalid = 1'b0;
        #1 compare_all();
        @(posedge clk);
        m_tready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        s_axis_fcp_tvalid = 1'b0;
        s_axis_fcp_tdata  = '0;
        fcp_ready = 1'b0;
        @(negedge clk);
        apply_reset();

        // Single beat.
        cycle(1'b1, make_beat(15'd5, 32'h10, 32'h20, 32'h30, -1), 1'b1);
        check("single_valid", 64'(fcp_valid), 64'd1);
        check("single_vc",    64'(fcp_vc), 64'd5);
        cycle(1'b0, '0, 1'b1);
        check("single_level", 64'(fifo_level), 64'd0);
        cycle(1'b0, '0, 1'b1);

        // Backpressure fill: 5 offered, 4 accepted.
        for (int i = 0; i < 5; i++) cycle(1'b1, make_beat(QW'(i), 32'(i), 32'(i + 100), 32'(i + 200), -1), 1'b0);
        check("bp_level", 64'(fifo_level), 64'd4);
        check("bp_tready", 64'(s_axis_fcp_tready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            check("bp_order", 64'(fcp_vc), 64'(i));
            cycle(1'b0, '0, 1'b1);
        end
        cycle(1'b0, '0, 1'b1);

        // Malformed beats from a clean reset.
        @(negedge clk);
        apply_reset();
        cycle(1'b1, make_beat(15'd3, 32'h1, 32'h2, 32'h3, 511), 1'b1);
        cycle(1'b1, make_beat(15'h7fff, 32'h1, 32'h2, 32'h3, -1), 1'b1);
        cycle(1'b0, '0, 1'b1);
        check("mal_drop", 64'(stat_drop_count), 64'd2);
        check("mal_rx",   64'(stat_rx_count), 64'd0);

        // Streaming: 20 back-to-back good beats.
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, rand_beat(1'b0), 1'b1);
            check("stream_level", 64'(fifo_level <= 1), 64'd1);
        end
        cycle(1'b0, '0, 1'b1);

        // Random traffic with some malformed beats and random backpressure.
        for (int i = 0; i < 250; i++)
            cycle($urandom_range(0, 3) != 0, rand_beat($urandom_range(0, 4) == 0), $urandom_range(0, 2) != 0);
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1);

        // Mid-operation reset with 3 entries buffered.
        for (int i = 0; i < 3; i++) cycle(1'b1, rand_beat(1'b0), 1'b0);
        check("pre_rst_level", 64'(fifo_level), 64'd3);
        apply_reset();

        // Saturation of the 4-bit good-beat counter.
        for (int i = 0; i < 20; i++) cycle(1'b1, rand_beat(1'b0), 1'b1);
        cycle(1'b0, '0, 1'b1);
        check("sat_rx", 64'(stat_rx_count), 64'(MAXC));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
